// File: rtl/pulse_sequencer.sv
// pulse_sequencer: per-period pulse-1/CPMG pulse train and receiver-blanking gate with period-boundary parameter shadowing
module pulse_sequencer #(
  parameter int PER_SHIFT = 16,
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [7:0]  cp,
  input  logic        pu,
  input  logic        bl,
  input  logic [15:0] p_bl_off,
  input  logic        rxd,
  output logic        pulse,
  output logic        inhib,
  output logic        sync,
  output logic        overrun
);
  localparam int PC_W = 8 + PER_SHIFT;
  typedef enum logic [2:0] {IDLE, LOAD, P1, DEL, P2, HOLD, WAIT} state_t;
  typedef struct packed {
    logic [7:0]  per;
    logic [7:0]  cp;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [15:0] p_bl_off;
    logic        pu;
    logic        bl;
  } shadow_t;
  state_t state_q, state_d;
  shadow_t sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] rem_q, rem_d, seq_rem;
  logic [PC_W-1:0] pc_q, pc_d;
  logic pulse_q, pulse_d, inhib_q, inhib_d, sync_q, sync_d, overrun_q, overrun_d;
  logic in_seq, expire, last;
  assign in_seq = state_q inside {P1, DEL, P2, HOLD};
  assign last = cnt_q == CNT_W'(1);
  assign expire = state_q != IDLE && pc_q == (PC_W'(sh_q.per) << PER_SHIFT) - PC_W'(1);
  assign pulse = pulse_q;
  assign inhib = inhib_q;
  assign sync = sync_q;
  assign overrun = overrun_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      pc_q <= '0;
      pulse_q <= 1'b0;
      inhib_q <= 1'b0;
      sync_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      pc_q <= pc_d;
      pulse_q <= pulse_d;
      inhib_q <= inhib_d;
      sync_q <= sync_d;
      overrun_q <= overrun_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - CNT_W'(1);
    rem_d = rem_q;
    seq_rem = state_q == LOAD ? sh_q.cp : state_q == DEL ? rem_q - 8'd1 : rem_q;
    if (state_q == IDLE || rxd || expire)
      state_d = |per ? LOAD : IDLE;
    else if (state_q == LOAD && |sh_q.p1wid) begin
      state_d = P1;
      cnt_d = CNT_W'(sh_q.p1wid);
      rem_d = sh_q.cp;
    end else if (state_q == DEL && last && |sh_q.p2wid) begin
      state_d = P2;
      cnt_d = CNT_W'(sh_q.p2wid);
      rem_d = seq_rem;
    end else if (state_q == HOLD && last)
      state_d = WAIT;
    else if (state_q == LOAD || (in_seq && last)) begin
      if (|seq_rem && |sh_q.del) begin
        state_d = DEL;
        cnt_d = state_q inside {LOAD, P1} ? CNT_W'(sh_q.del) : CNT_W'(sh_q.del) << 1;
        rem_d = seq_rem;
      end else if (|seq_rem && |sh_q.p2wid) begin
        state_d = P2;
        cnt_d = CNT_W'(sh_q.p2wid);
        rem_d = seq_rem - 8'd1;
      end else if (|sh_q.p_bl_off) begin
        state_d = HOLD;
        cnt_d = CNT_W'(sh_q.p_bl_off);
      end else
        state_d = WAIT;
    end
    pc_d = state_d inside {IDLE, LOAD} ? '0 : pc_q + PC_W'(1);
    sh_d = state_d == LOAD ? shadow_t'({per, cp, p1wid, del, p2wid, p_bl_off, pu, bl}) : sh_q;
  end
  always_comb begin
    sync_d = state_d == LOAD;
    overrun_d = sync_d && expire && !rxd && in_seq;
    pulse_d = state_d == P2 || (state_d == P1 && sh_q.pu);
    inhib_d = sh_q.bl && state_d inside {P1, DEL, P2, HOLD};
  end
endmodule
